// File: rtl/pyramid_scale_sequencer_pkg.sv
// Package pyramid_pkg: default geometry, per-level tables, FSM state type and
// the source-coordinate helper shared by the pyramid scale sequencer.
//   LEVEL_W/LEVEL_H       : destination grid size of each level (index 0 = full scale)
//   LEVEL_STEP_X/Y        : Q16.16 source/destination ratio per level
//   state_t               : sequencer FSM states
//   src_coord()           : integer part of an accumulator, clamped to the frame edge
package pyramid_pkg;

  localparam int unsigned IMG_W_DEF  = 8;
  localparam int unsigned IMG_H_DEF  = 6;
  localparam int unsigned LEVELS_DEF = 2;
  localparam int unsigned PIX_W_DEF  = 32;
  localparam int unsigned FRAC_DEF   = 16;

  typedef logic [15:0] dim_t;
  typedef logic [31:0] step_t;

  // Packed tables: element [0] is level 0.
  localparam dim_t  [LEVELS_DEF-1:0] LEVEL_W      = {16'd4, 16'd8};
  localparam dim_t  [LEVELS_DEF-1:0] LEVEL_H      = {16'd3, 16'd6};
  localparam step_t [LEVELS_DEF-1:0] LEVEL_STEP_X = {32'h0002_0000, 32'h0001_0000};
  localparam step_t [LEVELS_DEF-1:0] LEVEL_STEP_Y = {32'h0002_0000, 32'h0001_0000};

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  function automatic logic [31:0] src_coord(input logic [31:0] acc,
                                            input int unsigned frac,
                                            input int unsigned lim);
    logic [31:0] w_int;
    w_int = acc >> frac;
    return (w_int > lim) ? 32'(lim) : w_int;
  endfunction

endpackage

// File: rtl/pyramid_scale_sequencer_fifo.sv
// pyr_skid_fifo: 2-entry valid/ready FIFO carrying pixel + coordinates + level
// + last flag to the downstream consumer.
//   in_valid/in_data   : write side (no back-pressure; producer tracks count)
//   out_valid/out_ready/out_data : read side, head held stable until accepted
//   count              : current occupancy 0..2
module pyr_skid_fifo #(
  parameter int unsigned DW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    count
);

  logic [DW-1:0] r_mem [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;
  logic          w_pop;
  logic          w_push;

  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_mem[r_rd_ptr];
  assign count     = r_count;
  assign w_pop     = out_valid && out_ready;
  // When full, a same-cycle pop frees the slot being written.
  assign w_push    = in_valid && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pyramid_scale_sequencer.sv
// pyramid_scale_sequencer: walks every pyramid level in raster order, derives
// nearest-neighbour source coordinates by Q16.FRAC step accumulation, reads the
// frame buffer and streams the scaled pixels through a 2-entry FIFO.
//   clock, reset_n          : clock, asynchronous active-low reset
//   start / busy / done     : pass control and status
//   src_rd_en/row/col/data  : frame-buffer read port (data 1 cycle after en)
//   out_valid/ready/data    : scaled pixel stream
//   out_x/out_y/out_level/out_last : destination coordinate, level, end of level
module pyramid_scale_sequencer
  import pyramid_pkg::*;
#(
  parameter int unsigned IMG_W  = IMG_W_DEF,
  parameter int unsigned IMG_H  = IMG_H_DEF,
  parameter int unsigned LEVELS = LEVELS_DEF,
  parameter int unsigned PIX_W  = PIX_W_DEF,
  parameter int unsigned FRAC   = FRAC_DEF,
  parameter dim_t  [LEVELS-1:0] LVL_W  = LEVEL_W,
  parameter dim_t  [LEVELS-1:0] LVL_H  = LEVEL_H,
  parameter step_t [LEVELS-1:0] STEP_X = LEVEL_STEP_X,
  parameter step_t [LEVELS-1:0] STEP_Y = LEVEL_STEP_Y
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      src_rd_en,
  output logic [$clog2(IMG_H)-1:0]  src_rd_row,
  output logic [$clog2(IMG_W)-1:0]  src_rd_col,
  input  logic [PIX_W-1:0]          src_rd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PIX_W-1:0]          out_data,
  output logic [$clog2(IMG_W)-1:0]  out_x,
  output logic [$clog2(IMG_H)-1:0]  out_y,
  output logic [$clog2(LEVELS)-1:0] out_level,
  output logic                      out_last
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam int unsigned LW = $clog2(LEVELS);
  localparam int unsigned DW = PIX_W + XW + YW + LW + 1;

  state_t        r_state;
  logic [LW-1:0] r_level;
  logic [XW-1:0] r_x, r_wmax, r_p_x;
  logic [YW-1:0] r_y, r_hmax, r_p_y;
  logic [LW-1:0] r_p_lvl;
  logic          r_p_last;
  step_t         r_sx, r_sy;
  logic [31:0]   r_acc_x, r_acc_y;
  logic          r_inflight;

  logic [1:0]    w_fifo_count;
  logic          w_fifo_valid;
  logic          w_pop;
  logic [2:0]    w_occ;
  logic          w_issue;
  logic          w_last_pix;
  logic          w_drained;
  logic [DW-1:0] w_fifo_in;
  logic [DW-1:0] w_fifo_out;

  assign w_pop      = w_fifo_valid && out_ready;
  // Occupancy counts the head leaving this cycle so the stream sustains one
  // pixel per cycle; FIFO entries plus the in-flight read never exceed 2.
  assign w_occ      = {1'b0, w_fifo_count} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue    = (r_state == SCAN) && (w_occ < 3'd2);
  assign w_last_pix = (r_x == r_wmax) && (r_y == r_hmax);
  // Leave DRAIN as the final entry is accepted so done follows it directly.
  assign w_drained  = !r_inflight &&
                      ((w_fifo_count == 2'd0) || ((w_fifo_count == 2'd1) && w_pop));

  assign busy       = (r_state == LOAD) || (r_state == SCAN) || (r_state == DRAIN);
  assign done       = (r_state == DONE);
  assign src_rd_en  = w_issue;
  assign src_rd_col = XW'(src_coord(r_acc_x, FRAC, IMG_W - 1));
  assign src_rd_row = YW'(src_coord(r_acc_y, FRAC, IMG_H - 1));

  assign w_fifo_in  = {src_rd_data, r_p_x, r_p_y, r_p_lvl, r_p_last};
  assign {out_data, out_x, out_y, out_level, out_last} = w_fifo_out;
  assign out_valid  = w_fifo_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_level    <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_wmax     <= '0;
      r_hmax     <= '0;
      r_sx       <= '0;
      r_sy       <= '0;
      r_acc_x    <= '0;
      r_acc_y    <= '0;
      r_inflight <= 1'b0;
      r_p_x      <= '0;
      r_p_y      <= '0;
      r_p_lvl    <= '0;
      r_p_last   <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_p_x    <= r_x;
        r_p_y    <= r_y;
        r_p_lvl  <= r_level;
        r_p_last <= w_last_pix;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_level <= '0;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_wmax  <= XW'(LVL_W[r_level] - 16'd1);
          r_hmax  <= YW'(LVL_H[r_level] - 16'd1);
          r_sx    <= STEP_X[r_level];
          r_sy    <= STEP_Y[r_level];
          r_acc_x <= '0;
          r_acc_y <= '0;
          r_x     <= '0;
          r_y     <= '0;
          r_state <= SCAN;
        end
        SCAN: begin
          if (w_issue) begin
            if (r_x == r_wmax) begin
              r_x     <= '0;
              r_acc_x <= '0;
              r_y     <= r_y + YW'(1);
              r_acc_y <= r_acc_y + r_sy;
              if (w_last_pix) r_state <= DRAIN;
            end else begin
              r_x     <= r_x + XW'(1);
              r_acc_x <= r_acc_x + r_sx;
            end
          end
        end
        DRAIN: begin
          if (w_drained) begin
            if (r_level == LW'(LEVELS - 1)) begin
              r_state <= DONE;
            end else begin
              r_level <= r_level + LW'(1);
              r_state <= LOAD;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  pyr_skid_fifo #(
    .DW (DW)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (r_inflight),
    .in_data   (w_fifo_in),
    .out_valid (w_fifo_valid),
    .out_ready (out_ready),
    .out_data  (w_fifo_out),
    .count     (w_fifo_count)
  );

endmodule
